// File: rtl/ring_osc_counter.sv
// Rising-edge event counter clocked by a ring-oscillator output, gated by an
// enable that may be asynchronous to the oscillator and is synchronised into its domain.
module ring_osc_counter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SATURATE    = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             in,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] out
);

    logic             w_en_s;
    logic             w_full;
    logic             w_inc;
    logic [WIDTH-1:0] r_count;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_en_s = enable;
        end else begin : g_sync
            // Plain flop chain; stage 0 may go metastable, later stages filter it.
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge in or negedge reset) begin
                if (!reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= enable;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_en_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_full = &r_count;
    // Saturating mode simply suppresses the increment at all-ones.
    assign w_inc  = w_en_s && !((SATURATE != 0) && w_full);

    always_ff @(posedge in or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign out = r_count;

endmodule

// File: tb/tb_ring_osc_counter.sv
// Directed bench for ring_osc_counter: four instances cover 2-stage sync, 3-stage sync
// with saturation, narrow wrap-around and the bypassed synchroniser.
module tb_ring_osc_counter;

    logic        osc = 1'b0;
    logic        rst_m = 1'b0, en_m = 1'b0;
    logic        rst_w = 1'b0, en_w = 1'b0;
    logic        rst_s = 1'b0, en_s = 1'b0;
    logic        rst_b = 1'b0, en_b = 1'b0;
    logic [15:0] out_m;
    logic [7:0]  out_w;
    logic [7:0]  out_s;
    logic [15:0] out_b;

    int n_checks = 0;
    int n_fail   = 0;

    ring_osc_counter #(.WIDTH(16), .SATURATE(0), .SYNC_STAGES(2)) u_main (
        .in(osc), .reset(rst_m), .enable(en_m), .out(out_m));
    ring_osc_counter #(.WIDTH(8), .SATURATE(0), .SYNC_STAGES(2)) u_wrap (
        .in(osc), .reset(rst_w), .enable(en_w), .out(out_w));
    ring_osc_counter #(.WIDTH(8), .SATURATE(1), .SYNC_STAGES(3)) u_sat (
        .in(osc), .reset(rst_s), .enable(en_s), .out(out_s));
    ring_osc_counter #(.WIDTH(16), .SATURATE(0), .SYNC_STAGES(0)) u_byp (
        .in(osc), .reset(rst_b), .enable(en_b), .out(out_b));

    // 10 ns oscillator period; returns with osc low, 5 ns after the last rising edge.
    task automatic edges(input int n);
        repeat (n) begin
            #5 osc = 1'b1;
            #5 osc = 1'b0;
        end
    endtask

    task automatic test_reset();
        #100;
        n_checks++; if (out_m !== 16'd0) begin n_fail++; $display("FAIL reset_hold_m: got %0h want 0", out_m); end
        n_checks++; if (out_b !== 16'd0) begin n_fail++; $display("FAIL reset_hold_b: got %0h want 0", out_b); end
        rst_m = 1'b1; rst_w = 1'b1; rst_s = 1'b1; rst_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            n_checks++; if (out_m !== 16'd0) begin n_fail++; $display("FAIL reset_idle_m[%0d]: got %0d want 0", i, out_m); end
            n_checks++; if (out_w !== 8'd0)  begin n_fail++; $display("FAIL reset_idle_w[%0d]: got %0d want 0", i, out_w); end
            n_checks++; if (out_s !== 8'd0)  begin n_fail++; $display("FAIL reset_idle_s[%0d]: got %0d want 0", i, out_s); end
            n_checks++; if (out_b !== 16'd0) begin n_fail++; $display("FAIL reset_idle_b[%0d]: got %0d want 0", i, out_b); end
        end
    endtask

    // Enable high across edges 1..49 and low from edge 50: increments land on edges 3..51.
    task automatic test_gated_count();
        en_m = 1'b1;
        edges(2);
        n_checks++; if (out_m !== 16'd0)  begin n_fail++; $display("FAIL gate_latency: got %0d want 0", out_m); end
        edges(1);
        n_checks++; if (out_m !== 16'd1)  begin n_fail++; $display("FAIL gate_first: got %0d want 1", out_m); end
        edges(46);
        n_checks++; if (out_m !== 16'd47) begin n_fail++; $display("FAIL gate_49: got %0d want 47", out_m); end
        en_m = 1'b0;
        edges(1);
        n_checks++; if (out_m !== 16'd48) begin n_fail++; $display("FAIL gate_50: got %0d want 48", out_m); end
        edges(1);
        n_checks++; if (out_m !== 16'd49) begin n_fail++; $display("FAIL gate_last: got %0d want 49", out_m); end
        edges(8);
        n_checks++; if (out_m !== 16'd49) begin n_fail++; $display("FAIL gate_hold: got %0d want 49", out_m); end
    endtask

    task automatic test_async_reset();
        #2 rst_m = 1'b0;
        #1 rst_m = 1'b1;
        n_checks++; if (out_m !== 16'd0)   begin n_fail++; $display("FAIL mid_clear: got %0d want 0", out_m); end
        en_m = 1'b1;
        edges(102);
        n_checks++; if (out_m !== 16'd100) begin n_fail++; $display("FAIL mid_count: got %0d want 100", out_m); end
        #2 rst_m = 1'b0;
        #1;
        n_checks++; if (out_m !== 16'd0)   begin n_fail++; $display("FAIL mid_async: got %0d want 0", out_m); end
        edges(3);
        n_checks++; if (out_m !== 16'd0)   begin n_fail++; $display("FAIL mid_in_reset: got %0d want 0", out_m); end
        rst_m = 1'b1;
        edges(2);
        n_checks++; if (out_m !== 16'd0)   begin n_fail++; $display("FAIL mid_resync: got %0d want 0", out_m); end
        edges(1);
        n_checks++; if (out_m !== 16'd1)   begin n_fail++; $display("FAIL mid_restart: got %0d want 1", out_m); end
        edges(4);
        n_checks++; if (out_m !== 16'd5)   begin n_fail++; $display("FAIL mid_resume: got %0d want 5", out_m); end
    endtask

    // Reset falling in the same time step as an oscillator rising edge.
    task automatic test_reset_edge_collision();
        #5;
        rst_m = 1'b0;
        osc   = 1'b1;
        #1;
        n_checks++; if (out_m !== 16'd0) begin n_fail++; $display("FAIL collide: got %0d want 0", out_m); end
        #4 osc = 1'b0;
        #5;
        en_m  = 1'b0;
        rst_m = 1'b1;
        edges(4);
        n_checks++; if (out_m !== 16'd0) begin n_fail++; $display("FAIL collide_idle: got %0d want 0", out_m); end
    endtask

    task automatic test_wrap();
        en_w = 1'b1;
        edges(257);
        n_checks++; if (out_w !== 8'hFF) begin n_fail++; $display("FAIL wrap_top: got %0h want ff", out_w); end
        edges(1);
        n_checks++; if (out_w !== 8'h00) begin n_fail++; $display("FAIL wrap_zero: got %0h want 0", out_w); end
        edges(1);
        n_checks++; if (out_w !== 8'h01) begin n_fail++; $display("FAIL wrap_next: got %0h want 1", out_w); end
        en_w = 1'b0;
    endtask

    // Three sync stages: after N enabled edges the count is N-3.
    task automatic test_saturate();
        en_s = 1'b1;
        edges(3);
        n_checks++; if (out_s !== 8'd0)  begin n_fail++; $display("FAIL sat_latency: got %0d want 0", out_s); end
        edges(254);
        n_checks++; if (out_s !== 8'd254) begin n_fail++; $display("FAIL sat_near: got %0d want 254", out_s); end
        edges(1);
        n_checks++; if (out_s !== 8'hFF) begin n_fail++; $display("FAIL sat_top: got %0h want ff", out_s); end
        edges(3);
        n_checks++; if (out_s !== 8'hFF) begin n_fail++; $display("FAIL sat_stick: got %0h want ff", out_s); end
        en_s = 1'b0;
    endtask

    task automatic test_bypass();
        en_b = 1'b1;
        edges(1);
        n_checks++; if (out_b !== 16'd1) begin n_fail++; $display("FAIL byp_first: got %0d want 1", out_b); end
        edges(4);
        n_checks++; if (out_b !== 16'd5) begin n_fail++; $display("FAIL byp_five: got %0d want 5", out_b); end
        en_b = 1'b0;
        edges(1);
        n_checks++; if (out_b !== 16'd5) begin n_fail++; $display("FAIL byp_stop: got %0d want 5", out_b); end
    endtask

    initial begin
        test_reset();
        test_gated_count();
        test_async_reset();
        test_reset_edge_collision();
        test_wrap();
        test_saturate();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
